// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types and constants for the host transmitter and receiver
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  typedef logic [7:0] ps2_byte_t;

  localparam int        PS2_FRAME_BITS = 10;
  localparam ps2_byte_t PS2_CMD_RESET  = 8'hFF;
  localparam ps2_byte_t PS2_CMD_SETLED = 8'hED;
  localparam ps2_byte_t PS2_CMD_ENABLE = 8'hF4;

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake and completion status of the PS/2 transmitter
interface ps2_host_tx_if;
  import ps2_pkg::*;

  ps2_byte_t tx_data;
  logic      tx_valid;
  logic      tx_ready;
  logic      done;
  logic      err_ack;
  logic      err_timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, done, err_ack, err_timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, done, err_ack, err_timeout
  );

endinterface

// File: rtl/ps2_edge_filter.sv
// rtl/ps2_edge_filter.sv - pad synchroniser and ps2_clk falling-edge pulse
// Optional ps2_clk stability filter with PS2_TX_GLITCH_FILTER_EN.
module ps2_edge_filter
`ifdef PS2_TX_GLITCH_FILTER_EN
#(
  parameter int FILT_LEN = 8
)
`endif
(
  input  logic msoc_clk,
  input  logic rstn,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  // Idle bus is high, so synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  assign data_s = data_sync[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] fcnt;
  logic          clk_filt;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      fcnt     <= '0;
      clk_filt <= 1'b1;
    end else if (clk_sync[1] == clk_filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT_LEN - 1)) begin
      fcnt     <= '0;
      clk_filt <= clk_sync[1];
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  assign clk_s = clk_filt;
`else
  assign clk_s = clk_sync[1];
`endif

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      clk_prev <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_prev <= clk_s;
      clk_fall <= clk_prev & ~clk_s;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter, open-drain outputs
// Optional ps2_clk glitch filter with PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
`ifdef PS2_TX_GLITCH_FILTER_EN
  ,
  parameter int FILT_LEN = 8
`endif
) (
  input  logic         msoc_clk,
  input  logic         rstn,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  output logic         rx_inhibit
);

  localparam int CW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_FRAME_BITS + 1);

  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PS2_FRAME_BITS - 1);

  ps2_tx_state_t              state;
  logic [PS2_FRAME_BITS-1:0]  frame;
  logic [CW-1:0]              cnt;
  logic [TW-1:0]              tmo;
  logic [BW-1:0]              bitcnt;
  logic                       ack_bit;
  logic                       tx_ready_r;
  logic                       done_r;
  logic                       err_ack_r;
  logic                       err_timeout_r;

  logic clk_s;
  logic data_s;
  logic clk_fall;

  ps2_edge_filter
`ifdef PS2_TX_GLITCH_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_edge (
    .msoc_clk   (msoc_clk),
    .rstn       (rstn),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fall   (clk_fall)
  );

  assign bus.tx_ready    = tx_ready_r;
  assign bus.done        = done_r;
  assign bus.err_ack     = err_ack_r;
  assign bus.err_timeout = err_timeout_r;

  // tmo counts the REQ cycle and every clk_fall cycle as the first of a new interval.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      frame         <= '0;
      cnt           <= '0;
      tmo           <= '0;
      bitcnt        <= '0;
      ack_bit       <= 1'b1;
      tx_ready_r    <= 1'b1;
      done_r        <= 1'b0;
      err_ack_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      ps2_clk_oe    <= 1'b0;
      ps2_data_oe   <= 1'b0;
      rx_inhibit    <= 1'b0;
    end else begin
      done_r        <= 1'b0;
      err_ack_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_ready_r && bus.tx_valid) begin
            frame      <= {1'b1, ~^bus.tx_data, bus.tx_data};
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            rx_inhibit <= 1'b1;
            tx_ready_r <= 1'b0;
            state      <= INHIBIT;
          end else begin
            tx_ready_r <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= REQ;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REQ: begin
          ps2_clk_oe <= 1'b0;
          bitcnt     <= '0;
          tmo        <= TW'(1);
          state      <= DATA;
        end
        default: begin
          if (tmo == TMO_LAST) begin
            ps2_clk_oe    <= 1'b0;
            ps2_data_oe   <= 1'b0;
            rx_inhibit    <= 1'b0;
            done_r        <= 1'b1;
            err_timeout_r <= 1'b1;
            state         <= IDLE;
          end else begin
            tmo <= clk_fall ? TW'(1) : tmo + TW'(1);
            if (state == DATA && clk_fall) begin
              ps2_data_oe <= ~frame[bitcnt];
              bitcnt      <= bitcnt + BW'(1);
              if (bitcnt == BIT_LAST) begin
                state <= ACK;
              end
            end else if (state == ACK && clk_fall) begin
              ack_bit <= data_s;
              state   <= WAIT_IDLE;
            end else if (state == WAIT_IDLE && clk_s && data_s) begin
              done_r     <= 1'b1;
              err_ack_r  <= ack_bit;
              rx_inhibit <= 1'b0;
              state      <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
